// File: rtl/sw_alloc.sv
`default_nettype none
// ============================================================================
// Module   : sw_alloc
// Purpose  : 5-port wormhole switch allocator. Each output runs a round-robin
//            arbiter and holds its lock on the winner until the tail flit.
// Revision : 1.0 - initial release
// ============================================================================
module sw_alloc #(
    parameter int         NUM_PORTS = 5,
    parameter logic [2:0] IDLE_SEL  = 3'b111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid_n_i,
    input  logic       req_valid_s_i,
    input  logic       req_valid_e_i,
    input  logic       req_valid_w_i,
    input  logic       req_valid_l_i,
    input  logic [2:0] req_dir_n_i,
    input  logic [2:0] req_dir_s_i,
    input  logic [2:0] req_dir_e_i,
    input  logic [2:0] req_dir_w_i,
    input  logic [2:0] req_dir_l_i,
    input  logic       req_tail_n_i,
    input  logic       req_tail_s_i,
    input  logic       req_tail_e_i,
    input  logic       req_tail_w_i,
    input  logic       req_tail_l_i,
    input  logic       out_ready_n_i,
    input  logic       out_ready_s_i,
    input  logic       out_ready_e_i,
    input  logic       out_ready_w_i,
    input  logic       out_ready_l_i,
    output logic [2:0] address_route_n_o,
    output logic [2:0] address_route_s_o,
    output logic [2:0] address_route_e_o,
    output logic [2:0] address_route_w_o,
    output logic [2:0] address_route_l_o,
    output logic       valid_n_o,
    output logic       valid_s_o,
    output logic       valid_e_o,
    output logic       valid_w_o,
    output logic       valid_l_o,
    output logic       err_o
);

    logic [NUM_PORTS-1:0] w_req_valid;
    logic [NUM_PORTS-1:0] w_req_tail;
    logic [NUM_PORTS-1:0] w_out_ready;
    logic [2:0]           w_req_dir [NUM_PORTS];

    logic [NUM_PORTS-1:0] w_cand;
    logic [NUM_PORTS-1:0] w_illegal;
    logic [NUM_PORTS-1:0] w_gnt_vld;
    logic [NUM_PORTS-1:0] w_fire;
    logic [2:0]           w_gnt_idx [NUM_PORTS];
    logic [3:0]           w_pos;
    logic [NUM_PORTS-1:0] w_claimed;
    logic                 w_multi_gnt;

    logic [2:0]           r_rr_ptr    [NUM_PORTS];
    logic [2:0]           r_out_owner [NUM_PORTS];
    logic [NUM_PORTS-1:0] r_out_lock;
    logic [NUM_PORTS-1:0] r_in_locked;
    logic                 r_err;

    assign w_req_valid = {req_valid_l_i, req_valid_w_i, req_valid_e_i, req_valid_s_i, req_valid_n_i};
    assign w_req_tail  = {req_tail_l_i, req_tail_w_i, req_tail_e_i, req_tail_s_i, req_tail_n_i};
    assign w_out_ready = {out_ready_l_i, out_ready_w_i, out_ready_e_i, out_ready_s_i, out_ready_n_i};
    assign w_req_dir[0] = req_dir_n_i;
    assign w_req_dir[1] = req_dir_s_i;
    assign w_req_dir[2] = req_dir_e_i;
    assign w_req_dir[3] = req_dir_w_i;
    assign w_req_dir[4] = req_dir_l_i;

    // Only unlocked inputs present a routable head; locked inputs' dir is don't-care.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_cand[i]    = w_req_valid[i] && !r_in_locked[i]
                           && (w_req_dir[i] < 3'(NUM_PORTS)) && (w_req_dir[i] != 3'(i));
            w_illegal[i] = w_req_valid[i] && !r_in_locked[i] && !w_cand[i];
        end
    end

    always_comb begin
        w_pos = 4'd0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            w_gnt_vld[o] = 1'b0;
            w_gnt_idx[o] = 3'd0;
            if (r_out_lock[o]) begin
                w_gnt_idx[o] = r_out_owner[o];
                w_gnt_vld[o] = w_req_valid[r_out_owner[o]] && w_out_ready[o];
            end else if (w_out_ready[o]) begin
                // Scan farthest-first so the candidate closest to the pointer wins.
                for (int k = NUM_PORTS - 1; k >= 0; k--) begin
                    w_pos = {1'b0, r_rr_ptr[o]} + 4'(k);
                    if (w_pos >= 4'(NUM_PORTS)) begin
                        w_pos = w_pos - 4'(NUM_PORTS);
                    end
                    if (w_cand[w_pos[2:0]] && (w_req_dir[w_pos[2:0]] == 3'(o))) begin
                        w_gnt_vld[o] = 1'b1;
                        w_gnt_idx[o] = w_pos[2:0];
                    end
                end
            end
        end
    end

    assign w_fire = w_gnt_vld & {NUM_PORTS{!rst}};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                r_rr_ptr[o]    <= 3'd0;
                r_out_owner[o] <= 3'd0;
            end
            r_out_lock  <= '0;
            r_in_locked <= '0;
            r_err       <= 1'b0;
        end else begin
            if (|w_illegal) begin
                r_err <= 1'b1;
            end
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (w_fire[o]) begin
                    if (w_req_tail[w_gnt_idx[o]]) begin
                        r_out_lock[o]               <= 1'b0;
                        r_in_locked[w_gnt_idx[o]]   <= 1'b0;
                        r_rr_ptr[o] <= (w_gnt_idx[o] == 3'(NUM_PORTS - 1)) ? 3'd0
                                                                           : w_gnt_idx[o] + 3'd1;
                    end else if (!r_out_lock[o]) begin
                        r_out_lock[o]               <= 1'b1;
                        r_out_owner[o]              <= w_gnt_idx[o];
                        r_in_locked[w_gnt_idx[o]]   <= 1'b1;
                    end
                end
            end
        end
    end

    assign address_route_n_o = w_fire[0] ? w_gnt_idx[0] : IDLE_SEL;
    assign address_route_s_o = w_fire[1] ? w_gnt_idx[1] : IDLE_SEL;
    assign address_route_e_o = w_fire[2] ? w_gnt_idx[2] : IDLE_SEL;
    assign address_route_w_o = w_fire[3] ? w_gnt_idx[3] : IDLE_SEL;
    assign address_route_l_o = w_fire[4] ? w_gnt_idx[4] : IDLE_SEL;
    assign valid_n_o = w_fire[0];
    assign valid_s_o = w_fire[1];
    assign valid_e_o = w_fire[2];
    assign valid_w_o = w_fire[3];
    assign valid_l_o = w_fire[4];
    assign err_o     = r_err;

    // An input popped by two outputs in one cycle would duplicate a flit.
    always_comb begin
        w_multi_gnt = 1'b0;
        w_claimed   = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (w_fire[o]) begin
                if (w_claimed[w_gnt_idx[o]]) begin
                    w_multi_gnt = 1'b1;
                end
                w_claimed[w_gnt_idx[o]] = 1'b1;
            end
        end
    end

    a_single_output: assert property (@(posedge clk) disable iff (rst) !w_multi_gnt);

endmodule
`default_nettype wire

// File: tb/tb_sw_alloc.sv
`default_nettype none
// ============================================================================
// Module   : tb_sw_alloc
// Purpose  : Directed and randomized bench for sw_alloc against an
//            output-ownership reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sw_alloc;

    logic       clk;
    logic       rst;
    logic [4:0] rv;
    logic [4:0] tl;
    logic [4:0] rdy;
    logic [2:0] rd [5];
    logic [2:0] dut_sel [5];
    logic       dut_vld [5];
    logic       dut_err;

    int n_checks;
    int n_errors;
    int cyc;

    // Reference state: owner of each output (-1 = free) and round-robin start.
    int m_owner [5];
    int m_ptr   [5];
    bit m_err;
    bit exp_vld [5];
    int exp_sel [5];
    bit busy_in [5];

    sw_alloc dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid_n_i    (rv[0]),
        .req_valid_s_i    (rv[1]),
        .req_valid_e_i    (rv[2]),
        .req_valid_w_i    (rv[3]),
        .req_valid_l_i    (rv[4]),
        .req_dir_n_i      (rd[0]),
        .req_dir_s_i      (rd[1]),
        .req_dir_e_i      (rd[2]),
        .req_dir_w_i      (rd[3]),
        .req_dir_l_i      (rd[4]),
        .req_tail_n_i     (tl[0]),
        .req_tail_s_i     (tl[1]),
        .req_tail_e_i     (tl[2]),
        .req_tail_w_i     (tl[3]),
        .req_tail_l_i     (tl[4]),
        .out_ready_n_i    (rdy[0]),
        .out_ready_s_i    (rdy[1]),
        .out_ready_e_i    (rdy[2]),
        .out_ready_w_i    (rdy[3]),
        .out_ready_l_i    (rdy[4]),
        .address_route_n_o(dut_sel[0]),
        .address_route_s_o(dut_sel[1]),
        .address_route_e_o(dut_sel[2]),
        .address_route_w_o(dut_sel[3]),
        .address_route_l_o(dut_sel[4]),
        .valid_n_o        (dut_vld[0]),
        .valid_s_o        (dut_vld[1]),
        .valid_e_o        (dut_vld[2]),
        .valid_w_o        (dut_vld[3]),
        .valid_l_o        (dut_vld[4]),
        .err_o            (dut_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int o = 0; o < 5; o++) begin
            m_owner[o] = -1;
            m_ptr[o]   = 0;
        end
        m_err = 1'b0;
    endtask

    function automatic bit legal_dir(input int i);
        return (int'(rd[i]) < 5) && (int'(rd[i]) != i);
    endfunction

    task automatic model_eval();
        for (int i = 0; i < 5; i++) begin
            busy_in[i] = 1'b0;
            for (int o = 0; o < 5; o++) if (m_owner[o] == i) busy_in[i] = 1'b1;
        end
        for (int o = 0; o < 5; o++) begin
            exp_vld[o] = 1'b0;
            exp_sel[o] = 7;
            if (!rst && rdy[o]) begin
                if (m_owner[o] >= 0) begin
                    if (rv[m_owner[o]]) begin
                        exp_vld[o] = 1'b1;
                        exp_sel[o] = m_owner[o];
                    end
                end else begin
                    for (int k = 0; k < 5; k++) begin
                        int c;
                        c = (m_ptr[o] + k) % 5;
                        if (!exp_vld[o] && rv[c] && !busy_in[c] && legal_dir(c) && int'(rd[c]) == o) begin
                            exp_vld[o] = 1'b1;
                            exp_sel[o] = c;
                        end
                    end
                end
            end
        end
    endtask

    task automatic model_update();
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < 5; i++)
                if (rv[i] && !busy_in[i] && !legal_dir(i)) m_err = 1'b1;
            for (int o = 0; o < 5; o++) begin
                if (exp_vld[o]) begin
                    if (tl[exp_sel[o]]) begin
                        m_owner[o] = -1;
                        m_ptr[o]   = (exp_sel[o] + 1) % 5;
                    end else if (m_owner[o] < 0) begin
                        m_owner[o] = exp_sel[o];
                    end
                end
            end
        end
    endtask

    // Inputs are already applied; compare on the falling edge, then advance.
    task automatic run_cycle(input int plan_route_l);
        model_eval();
        @(negedge clk);
        for (int o = 0; o < 5; o++) begin
            check_val($sformatf("valid[%0d]", o), int'(dut_vld[o]), int'(exp_vld[o]));
            check_val($sformatf("route[%0d]", o), int'(dut_sel[o]), exp_sel[o]);
        end
        check_val("err", int'(dut_err), int'(m_err));
        if (plan_route_l >= 0) check_val("plan_route_l", int'(dut_sel[4]), plan_route_l);
        model_update();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        rv  = '0;
        tl  = '0;
        rdy = '0;
        for (int i = 0; i < 5; i++) rd[i] = 3'd0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        idle_inputs();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        run_cycle(7);            // reset held: outputs idle, err clear
        rst = 1'b0;

        // N, S, E each send a single flit to L; expected order N, S, E.
        rdy = 5'b10000;
        tl  = 5'b00111;
        rd[0] = 3'd4; rd[1] = 3'd4; rd[2] = 3'd4;
        rv = 5'b00111; run_cycle(0);
        rv = 5'b00110; run_cycle(1);
        rv = 5'b00100; run_cycle(2);
        // With rr_ptr[L]=3, W beats N even though N is listed first.
        rv = 5'b01001; rd[3] = 3'd4; tl = 5'b01001; run_cycle(3);

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 149) == 0);
            for (int i = 0; i < 5; i++) begin
                rv[i]  = ($urandom_range(0, 3) != 0);
                tl[i]  = ($urandom_range(0, 2) == 0);
                rdy[i] = ($urandom_range(0, 3) != 0);
                rd[i]  = ($urandom_range(0, 99) < 2) ? 3'($urandom_range(5, 7))
                                                      : 3'($urandom_range(0, 4));
            end
            run_cycle(-1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
